// File: rtl/parity_pkg.sv
// Shared constants and state type for the parity check scheduler.
// The state values are fixed so status decoders elsewhere can rely on them.
package parity_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam logic PARITY_EVEN = 1'b0;

    localparam int DEFAULT_DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        CHECK = ST_CHECK,
        RESP  = ST_RESP
    } state_e;

endpackage

// File: rtl/parity_checker.sv
// Combinational even-parity checker: flags an error when the data plus
// parity bit carry an odd number of ones.
module parity_checker
    import parity_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic              parity_bit,
    output logic              error_flag
);

    assign error_flag = (^{data_in, parity_bit}) != PARITY_EVEN;

endmodule

// File: rtl/parity_check_scheduler.sv
// Round-robin scheduler sharing one parity checker among N_REQ requesters,
// with a registered tagged response and a saturating error counter.
module parity_check_scheduler
    import parity_pkg::*;
#(
    parameter  int N_REQ  = 4,
    parameter  int DATA_W = DEFAULT_DATA_W,
    parameter  int CNT_W  = 8,
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_parity,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [DATA_W-1:0]       resp_data,
    output logic                    resp_error,
    input  logic                    err_clr,
    output logic [CNT_W-1:0]        err_count,
    output logic                    busy
);

    state_e              state_q;
    logic [ID_W-1:0]     last_q;
    logic [DATA_W-1:0]   opData_q;
    logic                opParity_q;
    logic [ID_W-1:0]     opId_q;
    logic                respValid_q;
    logic                respError_q;
    logic [ID_W-1:0]     respId_q;
    logic [DATA_W-1:0]   respData_q;
    logic [CNT_W-1:0]    errCnt_q;
    logic [CNT_W-1:0]    errCnt_d;

    logic                grantValid;
    logic [ID_W-1:0]     grantId;
    logic                checkErr;

    // Scan downward in offset so the requester closest after last_q wins.
    always_comb begin
        grantValid = 1'b0;
        grantId    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req_valid[(int'(last_q) + k) % N_REQ]) begin
                grantValid = 1'b1;
                grantId    = ID_W'((int'(last_q) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grantValid) begin
            req_ready[grantId] = 1'b1;
        end
    end

    parity_checker #(
        .DATA_W(DATA_W)
    ) u_checker (
        .data_in   (opData_q),
        .parity_bit(opParity_q),
        .error_flag(checkErr)
    );

    // Clear takes priority over a same-cycle increment.
    always_comb begin
        errCnt_d = errCnt_q;
        if (err_clr) begin
            errCnt_d = '0;
        end else if (state_q == CHECK && checkErr && errCnt_q != {CNT_W{1'b1}}) begin
            errCnt_d = errCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= ID_W'(N_REQ - 1);
            opData_q    <= '0;
            opParity_q  <= 1'b0;
            opId_q      <= '0;
            respValid_q <= 1'b0;
            respError_q <= 1'b0;
            respId_q    <= '0;
            respData_q  <= '0;
            errCnt_q    <= '0;
        end else begin
            errCnt_q <= errCnt_d;
            case (state_q)
                IDLE: begin
                    if (grantValid) begin
                        opData_q   <= req_data[grantId*DATA_W +: DATA_W];
                        opParity_q <= req_parity[grantId];
                        opId_q     <= grantId;
                        last_q     <= grantId;
                        state_q    <= CHECK;
                    end
                end
                CHECK: begin
                    respError_q <= checkErr;
                    respData_q  <= opData_q;
                    respId_q    <= opId_q;
                    respValid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        respValid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid = respValid_q;
    assign resp_error = respError_q;
    assign resp_id    = respId_q;
    assign resp_data  = respData_q;
    assign err_count  = errCnt_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_parity_check_scheduler.sv
// Self-checking bench for parity_check_scheduler against a behavioural
// round-robin / even-parity / saturating-counter model.
module tb_parity_check_scheduler;

    localparam int N   = 4;
    localparam int DW  = 4;
    localparam int CW  = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_parity;
    logic [N-1:0]    req_ready;
    logic            resp_valid;
    logic            resp_ready;
    logic [1:0]      resp_id;
    logic [DW-1:0]   resp_data;
    logic            resp_error;
    logic            err_clr;
    logic [CW-1:0]   err_count;
    logic            busy;

    int vectors = 0;
    int miscompares = 0;
    int mLast = N - 1;
    int mErr = 0;
    int cycCnt = 0;

    parity_check_scheduler #(
        .N_REQ (N),
        .DATA_W(DW),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_parity(req_parity),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id   (resp_id),
        .resp_data (resp_data),
        .resp_error(resp_error),
        .err_clr   (err_clr),
        .err_count (err_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycCnt++;

    function automatic int rrWinner(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Reference: the winner's nibble and its parity error, plus counter update.
    task automatic modelStep(input int w, input logic [N*DW-1:0] d, input logic [N-1:0] p,
                             input logic clr, output logic expErr, output logic [DW-1:0] expData);
        expData = d[w*DW +: DW];
        expErr  = ($countones({expData, p[w]}) % 2) == 1;
        mLast   = w;
        if (clr) mErr = 0;
        else if (expErr && mErr < MAXC) mErr = mErr + 1;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        req_parity = '0;
        resp_ready = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mLast = N - 1;
        mErr = 0;
    endtask

    // Presents one request, returns the observed grant and response latency.
    task automatic runTxn(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic [N-1:0] p,
                          input logic clr, output logic [N-1:0] rdy, output int lat);
        @(negedge clk);
        req_valid = v;
        req_data = d;
        req_parity = p;
        resp_ready = 1'b0;
        #1 rdy = req_ready;
        lat = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = '0;
                err_clr = clr;
            end else begin
                err_clr = 1'b0;
            end
            if (resp_valid) begin
                lat = c;
                break;
            end
        end
        err_clr = 1'b0;
    endtask

    task automatic releaseResp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        applyReset();
        @(negedge clk);
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_resp_valid got %b exp 0", resp_valid); end
        vectors++; if (resp_error !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_resp_error got %b exp 0", resp_error); end
        vectors++; if (resp_id !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_resp_id got %0d exp 0", resp_id); end
        vectors++; if (resp_data !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_resp_data got %h exp 0", resp_data); end
        vectors++; if (err_count !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_err_count got %0d exp 0", err_count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
        vectors++; if (req_ready !== 4'b0) begin miscompares++; $display("[TB] FAIL reset_req_ready got %b exp 0000", req_ready); end
    endtask

    task automatic test_single();
        logic [N-1:0] rdy;
        int lat;
        logic eErr;
        logic [DW-1:0] eData;
        runTxn(4'b0001, 16'h0003, 4'b0000, 1'b0, rdy, lat);
        modelStep(0, 16'h0003, 4'b0000, 1'b0, eErr, eData);
        vectors++; if (rdy !== 4'b0001) begin miscompares++; $display("[TB] FAIL single_ready got %b exp 0001", rdy); end
        vectors++; if (lat !== 2) begin miscompares++; $display("[TB] FAIL single_latency got %0d exp 2", lat); end
        vectors++; if (resp_id !== 2'd0) begin miscompares++; $display("[TB] FAIL single_id got %0d exp 0", resp_id); end
        vectors++; if (resp_data !== eData) begin miscompares++; $display("[TB] FAIL single_data got %h exp %h", resp_data, eData); end
        vectors++; if (resp_error !== eErr) begin miscompares++; $display("[TB] FAIL single_error got %b exp %b", resp_error, eErr); end
        vectors++; if (err_count !== CW'(mErr)) begin miscompares++; $display("[TB] FAIL single_count got %0d exp %0d", err_count, mErr); end
        releaseResp();
        vectors++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_release got valid=%b busy=%b exp 0/0", resp_valid, busy); end
    endtask

    task automatic test_error_backpressure();
        logic [N-1:0] rdy;
        int lat;
        logic eErr;
        logic [DW-1:0] eData;
        logic [N*DW-1:0] d;
        d = 16'h0700;
        runTxn(4'b0100, d, 4'b0000, 1'b0, rdy, lat);
        modelStep(2, d, 4'b0000, 1'b0, eErr, eData);
        vectors++; if (rdy !== 4'b0100) begin miscompares++; $display("[TB] FAIL bp_ready got %b exp 0100", rdy); end
        vectors++; if (lat !== 2) begin miscompares++; $display("[TB] FAIL bp_latency got %0d exp 2", lat); end
        for (int s = 0; s < 4; s++) begin
            vectors++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_error !== eErr || resp_data !== eData || busy !== 1'b1)
                begin miscompares++; $display("[TB] FAIL bp_hold[%0d] got v=%b id=%0d err=%b data=%h busy=%b exp 1/2/%b/%h/1", s, resp_valid, resp_id, resp_error, resp_data, busy, eErr, eData); end
            vectors++; if (err_count !== CW'(mErr)) begin miscompares++; $display("[TB] FAIL bp_count got %0d exp %0d", err_count, mErr); end
            @(negedge clk);
        end
        releaseResp();
        vectors++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_release got valid=%b busy=%b exp 0/0", resp_valid, busy); end
        vectors++; if (resp_id !== 2'd2 || resp_error !== eErr) begin miscompares++; $display("[TB] FAIL bp_sticky got id=%0d err=%b exp 2/%b", resp_id, resp_error, eErr); end
    endtask

    task automatic test_fairness();
        logic [N*DW-1:0] d;
        logic [N-1:0] p;
        logic eErr;
        logic [DW-1:0] eData;
        int lastCyc;
        int waited;
        int exp;
        applyReset();
        @(negedge clk);
        d = N*DW'($urandom);
        p = N'($urandom);
        req_data = d;
        req_parity = p;
        resp_ready = 1'b1;
        req_valid = '1;
        #1;
        lastCyc = 0;
        for (int g = 0; g < 5; g++) begin
            waited = 0;
            while (req_ready == '0 && waited < 8) begin
                @(negedge clk);
                waited++;
            end
            exp = rrWinner('1, mLast);
            modelStep(exp, d, p, 1'b0, eErr, eData);
            vectors++; if (req_ready !== N'(1 << exp)) begin miscompares++; $display("[TB] FAIL fair_grant[%0d] got %b exp %b", g, req_ready, N'(1 << exp)); end
            if (g > 0) begin
                vectors++; if (cycCnt - lastCyc !== 3) begin miscompares++; $display("[TB] FAIL fair_spacing[%0d] got %0d exp 3", g, cycCnt - lastCyc); end
            end
            lastCyc = cycCnt;
            @(negedge clk);
            if (g == 4) req_valid = '0;
        end
        repeat (3) @(negedge clk);
        resp_ready = 1'b0;
        vectors++; if (err_count !== CW'(mErr)) begin miscompares++; $display("[TB] FAIL fair_count got %0d exp %0d", err_count, mErr); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL fair_idle got busy=%b exp 0", busy); end
    endtask

    task automatic test_counter_edges();
        logic [N-1:0] rdy;
        logic [N-1:0] p;
        logic [N*DW-1:0] d;
        logic [DW-1:0] nib;
        logic eErr;
        logic [DW-1:0] eData;
        int lat;
        int w;
        applyReset();
        for (int i = 0; i < 6; i++) begin
            w = $urandom_range(0, N - 1);
            nib = DW'($urandom);
            d = '0;
            d[w*DW +: DW] = nib;
            p = '0;
            p[w] = ~(^nib);
            runTxn(N'(1 << w), d, p, (i == 5), rdy, lat);
            modelStep(w, d, p, (i == 5), eErr, eData);
            vectors++; if (resp_error !== 1'b1 || resp_id !== 2'(w)) begin miscompares++; $display("[TB] FAIL cnt_err[%0d] got err=%b id=%0d exp 1/%0d", i, resp_error, resp_id, w); end
            vectors++; if (err_count !== CW'(mErr)) begin miscompares++; $display("[TB] FAIL cnt_value[%0d] got %0d exp %0d", i, err_count, mErr); end
            releaseResp();
        end
    endtask

    task automatic test_reset_mid_check();
        logic [N-1:0] rdy;
        logic eErr;
        logic [DW-1:0] eData;
        int lat;
        @(negedge clk);
        req_data = 16'h0070;
        req_parity = 4'b0000;
        req_valid = 4'b0010;
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("[TB] FAIL mid_grant got %b exp 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_in_check got busy=%b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        vectors++; if (resp_valid !== 1'b0 || busy !== 1'b0 || err_count !== 2'd0 || req_ready !== 4'b0)
            begin miscompares++; $display("[TB] FAIL mid_reset got v=%b busy=%b cnt=%0d rdy=%b exp 0/0/0/0000", resp_valid, busy, err_count, req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        mLast = N - 1;
        mErr = 0;
        @(negedge clk);
        vectors++; if (resp_valid !== 1'b0 || err_count !== 2'd0) begin miscompares++; $display("[TB] FAIL mid_after got v=%b cnt=%0d exp 0/0", resp_valid, err_count); end
        runTxn(4'b0010, 16'h0070, 4'b0000, 1'b0, rdy, lat);
        modelStep(1, 16'h0070, 4'b0000, 1'b0, eErr, eData);
        vectors++; if (rdy !== 4'b0010 || lat !== 2) begin miscompares++; $display("[TB] FAIL mid_reissue got rdy=%b lat=%0d exp 0010/2", rdy, lat); end
        vectors++; if (resp_id !== 2'd1 || resp_error !== eErr || resp_data !== eData || err_count !== CW'(mErr))
            begin miscompares++; $display("[TB] FAIL mid_resp got id=%0d err=%b data=%h cnt=%0d exp 1/%b/%h/%0d", resp_id, resp_error, resp_data, err_count, eErr, eData, mErr); end
        releaseResp();
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        logic [N-1:0] p;
        logic [N-1:0] rdy;
        logic [N*DW-1:0] d;
        logic clr;
        logic eErr;
        logic [DW-1:0] eData;
        int lat;
        int w;
        int stall;
        for (int i = 0; i < 40; i++) begin
            v = N'($urandom_range(1, (1 << N) - 1));
            d = N*DW'($urandom);
            p = N'($urandom);
            clr = ($urandom_range(0, 7) == 0);
            w = rrWinner(v, mLast);
            runTxn(v, d, p, clr, rdy, lat);
            modelStep(w, d, p, clr, eErr, eData);
            vectors++; if (rdy !== N'(1 << w) || lat !== 2) begin miscompares++; $display("[TB] FAIL rnd_grant[%0d] got rdy=%b lat=%0d exp %b/2", i, rdy, lat, N'(1 << w)); end
            vectors++; if (resp_id !== 2'(w) || resp_data !== eData || resp_error !== eErr)
                begin miscompares++; $display("[TB] FAIL rnd_resp[%0d] got id=%0d data=%h err=%b exp %0d/%h/%b", i, resp_id, resp_data, resp_error, w, eData, eErr); end
            vectors++; if (err_count !== CW'(mErr)) begin miscompares++; $display("[TB] FAIL rnd_count[%0d] got %0d exp %0d", i, err_count, mErr); end
            stall = $urandom_range(0, 2);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                vectors++; if (resp_valid !== 1'b1 || resp_id !== 2'(w)) begin miscompares++; $display("[TB] FAIL rnd_stall[%0d] got v=%b id=%0d exp 1/%0d", i, resp_valid, resp_id, w); end
            end
            releaseResp();
            vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rnd_release[%0d] got %b exp 0", i, resp_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_error_backpressure();
        test_fairness();
        test_counter_edges();
        test_reset_mid_check();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout exp completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
